// File: rtl/iob_spi_fl_arbiter_pkg.sv
`default_nettype none
// iob_spi_fl_arbiter_pkg: FSM encodings, channel-read command defaults and the latched request record
// shared by the flash request arbiter and its round-robin picker.
package iob_spi_fl_arbiter_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] RD_CMD_DEF   = 8'h03;
  localparam logic [6:0] RD_NBITS_DEF = 7'd32;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] command;
  } fl_req_t;

  // Command word for native channel reads: all optional fields zero, bit count above the opcode.
  function automatic logic [31:0] chan_command(input logic [7:0] cmd, input logic [6:0] nbits);
    return {17'd0, nbits, cmd};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_spi_fl_rr_arb.sv
`default_nettype none
// iob_spi_fl_rr_arb: combinational N-input round-robin picker; the search starts one past ptr_i
// and wraps, so the most recently granted requester is considered last.
module iob_spi_fl_rr_arb
  import iob_spi_fl_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  int               cand;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = 0;
    sel         = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      sel = IDX_W'(cand);
      if (!grant_vld_o && req_i[sel]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_spi_fl_arbiter.sv
`default_nettype none
// iob_spi_fl_arbiter: round-robin arbiter of N_CH cache read channels plus one software channel in
// front of spi_master_fl; one transaction outstanding, guarded by a per-transaction watchdog.
module iob_spi_fl_arbiter
  import iob_spi_fl_arbiter_pkg::*;
#(
  parameter int         N_CH     = 2,
  parameter int         ADDR_W   = 24,
  parameter int         DATA_W   = 32,
  parameter logic [7:0] RD_CMD   = RD_CMD_DEF,
  parameter logic [6:0] RD_NBITS = RD_NBITS_DEF,
  parameter int         TMO_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [N_CH-1:0]          ch_ready,
  output logic                     ch_error,
  input  logic                     sw_valid,
  input  logic [31:0]              sw_address,
  input  logic [31:0]              sw_command,
  output logic                     sw_ready,
  output logic                     core_valid,
  output logic [31:0]              core_address,
  output logic [31:0]              core_command,
  input  logic [DATA_W-1:0]        core_dout,
  input  logic                     core_tready,
  output logic                     core_abort,
  output logic                     busy
);

  localparam int          N_REQ      = N_CH + 1;
  localparam int          IDX_W      = $clog2(N_REQ);
  localparam logic [31:0] CH_COMMAND = chan_command(RD_CMD, RD_NBITS);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  fl_req_t           req_q, req_d;
  logic [TMO_W-1:0]  wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  w_grant_idx;
  logic              w_grant_vld;
  logic [31:0]       w_ch_addr32 [N_CH];
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_cmd;
  logic [TMO_W-1:0]  w_wd_inc;
  logic              w_resp;

  iob_spi_fl_rr_arb #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req_i       ({sw_valid, ch_valid}),
    .ptr_i       (rr_q),
    .grant_idx_o (w_grant_idx),
    .grant_vld_o (w_grant_vld)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch_addr
    assign w_ch_addr32[i] = 32'(ch_addr[i*ADDR_W +: ADDR_W]);
  end

  always_comb begin
    w_sel_addr = sw_address;
    w_sel_cmd  = sw_command;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_addr = w_ch_addr32[i];
        w_sel_cmd  = CH_COMMAND;
      end
    end
  end

  assign w_wd_inc = wd_q + TMO_W'(1);

  // Only one transaction is ever in flight: arbitration happens in IDLE alone.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    req_d   = req_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant_vld) begin
          state_d       = S_ISSUE;
          grant_d       = w_grant_idx;
          req_d.address = w_sel_addr;
          req_d.command = w_sel_cmd;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving together with watchdog saturation is a normal completion.
        if (core_tready) begin
          state_d = S_RESP;
          rdata_d = core_dout;
          err_d   = 1'b0;
        end else if (&w_wd_inc) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          wd_d    = w_wd_inc;
        end else begin
          wd_d = w_wd_inc;
        end
      end
      S_RESP: begin
        rr_d    = grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      req_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      req_q   <= req_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign w_resp = (state_q == S_RESP);

  for (genvar i = 0; i < N_CH; i++) begin : g_rdy
    assign ch_ready[i] = w_resp && (grant_q == IDX_W'(i));
  end

  assign sw_ready     = w_resp && (grant_q == IDX_W'(N_CH));
  assign ch_error     = w_resp && err_q;
  assign core_abort   = w_resp && err_q;
  assign ch_rdata     = rdata_q;
  assign core_valid   = (state_q == S_ISSUE);
  assign core_address = req_q.address;
  assign core_command = req_q.command;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iob_spi_fl_arbiter.sv
`default_nettype none
// Scoreboard bench for iob_spi_fl_arbiter: DUT a uses the default watchdog, DUT b uses TMO_W=4.
module tb_iob_spi_fl_arbiter;

  localparam int          N_CH   = 2;
  localparam int          ADDR_W = 24;
  localparam int          DATA_W = 32;
  localparam logic [31:0] CH_CMD = 32'h0000_2003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   a_rst, b_rst;
  logic [N_CH-1:0]        a_ch_valid, b_ch_valid;
  logic [N_CH*ADDR_W-1:0] a_ch_addr, b_ch_addr;
  logic [DATA_W-1:0]      a_ch_rdata, b_ch_rdata;
  logic [N_CH-1:0]        a_ch_ready, b_ch_ready;
  logic                   a_ch_error, b_ch_error;
  logic                   a_sw_valid, b_sw_valid;
  logic [31:0]            a_sw_address, b_sw_address, a_sw_command, b_sw_command;
  logic                   a_sw_ready, b_sw_ready, a_core_valid, b_core_valid;
  logic [31:0]            a_core_address, b_core_address, a_core_command, b_core_command;
  logic [DATA_W-1:0]      a_core_dout, b_core_dout;
  logic                   a_core_tready, b_core_tready, a_core_abort, b_core_abort, a_busy, b_busy;

  iob_spi_fl_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut_a (
    .clk(clk), .rst(a_rst), .ch_valid(a_ch_valid), .ch_addr(a_ch_addr), .ch_rdata(a_ch_rdata),
    .ch_ready(a_ch_ready), .ch_error(a_ch_error), .sw_valid(a_sw_valid), .sw_address(a_sw_address),
    .sw_command(a_sw_command), .sw_ready(a_sw_ready), .core_valid(a_core_valid),
    .core_address(a_core_address), .core_command(a_core_command), .core_dout(a_core_dout),
    .core_tready(a_core_tready), .core_abort(a_core_abort), .busy(a_busy)
  );

  iob_spi_fl_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .ch_valid(b_ch_valid), .ch_addr(b_ch_addr), .ch_rdata(b_ch_rdata),
    .ch_ready(b_ch_ready), .ch_error(b_ch_error), .sw_valid(b_sw_valid), .sw_address(b_sw_address),
    .sw_command(b_sw_command), .sw_ready(b_sw_ready), .core_valid(b_core_valid),
    .core_address(b_core_address), .core_command(b_core_command), .core_dout(b_core_dout),
    .core_tready(b_core_tready), .core_abort(b_core_abort), .busy(b_busy)
  );

  typedef struct { int idx; logic [31:0] data; logic err; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] cmd; } iss_t;

  rsp_t a_rq[$], b_rq[$];
  iss_t a_iq[$], b_iq[$];
  int   n_chk = 0, n_err = 0;
  int   a_lat = 0, b_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Flash contents seen by the core model.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic rsp_chk(input string p, input int idx, input logic [31:0] rd, input logic err,
                         input logic abt, input rsp_t e);
    chk({p, "_grant_idx"}, 32'(idx), 32'(e.idx));
    chk({p, "_rdata"}, rd, e.data);
    chk({p, "_error"}, 32'(err), 32'(e.err));
    chk({p, "_abort"}, 32'(abt), 32'(e.err));
  endtask

  always @(negedge clk) begin : mon_a
    int   idx, hits;
    rsp_t e;
    iss_t q;
    hits = 0;
    idx  = 0;
    for (int i = 0; i < N_CH; i++) if (a_ch_ready[i]) begin hits++; idx = i; end
    if (a_sw_ready) begin hits++; idx = N_CH; end
    if (hits > 1) chk("a_ready_onehot", 32'(hits), 32'd1);
    if (hits != 0) begin
      if (a_rq.size() == 0) chk("a_rsp_pending", 32'(a_rq.size()), 32'd1);
      else begin
        e = a_rq.pop_front();
        rsp_chk("a", idx, a_ch_rdata, a_ch_error, a_core_abort, e);
      end
    end else if (a_core_abort || a_ch_error) begin
      chk("a_abort_stray", 32'({a_core_abort, a_ch_error}), 32'd0);
    end
    if (a_core_valid) begin
      if (a_iq.size() == 0) chk("a_issue_pending", 32'(a_iq.size()), 32'd1);
      else begin
        q = a_iq.pop_front();
        chk("a_core_address", a_core_address, q.addr);
        chk("a_core_command", a_core_command, q.cmd);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    int   idx, hits;
    rsp_t e;
    iss_t q;
    hits = 0;
    idx  = 0;
    for (int i = 0; i < N_CH; i++) if (b_ch_ready[i]) begin hits++; idx = i; end
    if (b_sw_ready) begin hits++; idx = N_CH; end
    if (hits > 1) chk("b_ready_onehot", 32'(hits), 32'd1);
    if (hits != 0) begin
      if (b_rq.size() == 0) chk("b_rsp_pending", 32'(b_rq.size()), 32'd1);
      else begin
        e = b_rq.pop_front();
        rsp_chk("b", idx, b_ch_rdata, b_ch_error, b_core_abort, e);
      end
    end else if (b_core_abort || b_ch_error) begin
      chk("b_abort_stray", 32'({b_core_abort, b_ch_error}), 32'd0);
    end
    if (b_core_valid) begin
      if (b_iq.size() == 0) chk("b_issue_pending", 32'(b_iq.size()), 32'd1);
      else begin
        q = b_iq.pop_front();
        chk("b_core_address", b_core_address, q.addr);
        chk("b_core_command", b_core_command, q.cmd);
      end
    end
  end

  // Core models: answer lat cycles after the start pulse; lat 0 means never answer.
  initial begin : core_a
    a_core_tready = 1'b0;
    a_core_dout   = '0;
    forever begin
      @(negedge clk);
      if (a_core_valid && a_lat > 0) begin
        repeat (a_lat) @(negedge clk);
        a_core_tready = 1'b1;
        a_core_dout   = mem_f(a_core_address);
        @(negedge clk);
        a_core_tready = 1'b0;
        a_core_dout   = '0;
      end
    end
  end

  initial begin : core_b
    b_core_tready = 1'b0;
    b_core_dout   = '0;
    forever begin
      @(negedge clk);
      if (b_core_valid && b_lat > 0) begin
        repeat (b_lat) @(negedge clk);
        b_core_tready = 1'b1;
        b_core_dout   = mem_f(b_core_address);
        @(negedge clk);
        b_core_tready = 1'b0;
        b_core_dout   = '0;
      end
    end
  end

  task automatic a_wait(input int n, input bit hold, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (a_ch_ready != '0 || a_sw_ready) begin
        got++;
        if (!hold) begin
          a_ch_valid = a_ch_valid & ~a_ch_ready;
          if (a_sw_ready) a_sw_valid = 1'b0;
        end
      end
    end
    if (got < n) chk("a_wait_expired", 32'(got), 32'(n));
  endtask

  task automatic b_wait(output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (b_ch_ready != '0 || b_sw_ready) begin
        b_ch_valid = b_ch_valid & ~b_ch_ready;
        if (b_sw_ready) b_sw_valid = 1'b0;
        return;
      end
    end
    chk("b_wait_expired", 32'(cyc), 32'd0);
  endtask

  initial begin : stim
    int cyc;
    a_rst = 1'b1; b_rst = 1'b1;
    a_ch_valid = '0; b_ch_valid = '0; a_ch_addr = '0; b_ch_addr = '0;
    a_sw_valid = 1'b0; b_sw_valid = 1'b0;
    a_sw_address = '0; b_sw_address = '0; a_sw_command = '0; b_sw_command = '0;
    repeat (3) @(negedge clk);
    chk("a_reset_flags", 32'({a_busy, a_core_valid, a_core_abort, a_ch_ready, a_sw_ready, a_ch_error}), 32'd0);
    chk("a_reset_rdata", a_ch_rdata, 32'd0);
    chk("a_reset_addr_cmd", a_core_address | a_core_command, 32'd0);
    chk("b_reset_flags", 32'({b_busy, b_core_valid, b_core_abort, b_ch_ready, b_sw_ready, b_ch_error}), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Single channel-0 read, core answers after 20 cycles.
    a_lat = 20;
    a_iq.push_back('{32'h0000_0100, CH_CMD});
    a_rq.push_back('{0, 32'hDEAD_BEEF, 1'b0});
    a_ch_addr[0 +: ADDR_W] = 24'h000100;
    a_ch_valid[0] = 1'b1;
    a_wait(1, 1'b0, cyc);
    chk("t1_latency", 32'(cyc), 32'd22);
    repeat (2) @(negedge clk);
    chk("t1_rdata_hold", a_ch_rdata, 32'hDEAD_BEEF);

    // Software command passes its own command word through.
    a_lat = 3;
    a_sw_address = 32'h0000_0400;
    a_sw_command = 32'h0000_0806;
    a_iq.push_back('{32'h0000_0400, 32'h0000_0806});
    a_rq.push_back('{N_CH, mem_f(32'h0000_0400), 1'b0});
    a_sw_valid = 1'b1;
    a_wait(1, 1'b0, cyc);
    @(negedge clk);

    // All requesters held: pointer now at sw, so rotation starts at ch0.
    a_ch_addr[0 +: ADDR_W]      = 24'h000200;
    a_ch_addr[ADDR_W +: ADDR_W] = 24'h123456;
    a_sw_address = 32'h00AB_CDEF;
    for (int r = 0; r < 2; r++) begin
      a_iq.push_back('{32'h0000_0200, CH_CMD});
      a_rq.push_back('{0, mem_f(32'h0000_0200), 1'b0});
      a_iq.push_back('{32'h0012_3456, CH_CMD});
      a_rq.push_back('{1, mem_f(32'h0012_3456), 1'b0});
      a_iq.push_back('{32'h00AB_CDEF, 32'h0000_0806});
      a_rq.push_back('{N_CH, mem_f(32'h00AB_CDEF), 1'b0});
    end
    a_ch_valid = 2'b11;
    a_sw_valid = 1'b1;
    a_wait(6, 1'b1, cyc);
    a_ch_valid = '0;
    a_sw_valid = 1'b0;
    @(negedge clk);

    // Reset five cycles into WAIT on a transaction that never completes.
    a_lat = 0;
    a_ch_addr[ADDR_W +: ADDR_W] = 24'h000300;
    a_iq.push_back('{32'h0000_0300, CH_CMD});
    a_ch_valid[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!a_core_valid && cyc < 20);
    chk("rst_issue_seen", 32'(a_core_valid), 32'd1);
    repeat (5) @(negedge clk);
    a_rst = 1'b1;
    a_ch_valid = '0;
    @(negedge clk);
    chk("rst_flags", 32'({a_busy, a_core_valid, a_core_abort, a_ch_ready, a_sw_ready, a_ch_error}), 32'd0);
    chk("rst_rdata", a_ch_rdata, 32'd0);
    chk("rst_addr_cmd", a_core_address | a_core_command, 32'd0);
    a_rst = 1'b0;
    @(negedge clk);

    // Pointer back at 0: sw (index 2) is searched before ch0.
    a_lat = 3;
    a_sw_address = 32'h0000_0500;
    a_ch_addr[0 +: ADDR_W] = 24'h000600;
    a_iq.push_back('{32'h0000_0500, 32'h0000_0806});
    a_rq.push_back('{N_CH, mem_f(32'h0000_0500), 1'b0});
    a_iq.push_back('{32'h0000_0600, CH_CMD});
    a_rq.push_back('{0, mem_f(32'h0000_0600), 1'b0});
    a_sw_valid = 1'b1;
    a_ch_valid[0] = 1'b1;
    a_wait(2, 1'b0, cyc);

    // DUT b: completion coincident with watchdog saturation wins.
    b_lat = 15;
    b_ch_addr[ADDR_W +: ADDR_W] = 24'h000020;
    b_iq.push_back('{32'h0000_0020, CH_CMD});
    b_rq.push_back('{1, mem_f(32'h0000_0020), 1'b0});
    b_ch_valid[1] = 1'b1;
    b_wait(cyc);
    chk("tie_latency", 32'(cyc), 32'd17);
    @(negedge clk);

    // DUT b: core never answers, abort after 15 WAIT cycles with zeroed data.
    b_lat = 0;
    b_ch_addr[0 +: ADDR_W] = 24'h000010;
    b_iq.push_back('{32'h0000_0010, CH_CMD});
    b_rq.push_back('{0, 32'd0, 1'b1});
    b_ch_valid[0] = 1'b1;
    b_wait(cyc);
    chk("tmo_latency", 32'(cyc), 32'd17);

    repeat (5) @(negedge clk);
    chk("a_rsp_left", 32'(a_rq.size() + a_iq.size()), 32'd0);
    chk("b_rsp_left", 32'(b_rq.size() + b_iq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
